// File: rtl/seq_num_alloc_if.sv
// Decode/commit/squash/redirect bundle around the sequence-number allocator.
// The master side drives requests and notifications; the slave side is the allocator.
interface seq_num_alloc_if #(
    parameter int p_seq_num_bits = 5
);
    logic                      alloc_val;
    logic                      alloc_rdy;
    logic [p_seq_num_bits-1:0] alloc_seq_num;
    logic                      commit_val;
    logic [p_seq_num_bits-1:0] commit_seq_num;
    logic                      squash_val;
    logic [p_seq_num_bits-1:0] squash_seq_num;
    logic [31:0]               squash_target;
    logic                      redirect_val;
    logic [31:0]               redirect_target;
    logic [p_seq_num_bits:0]   inflight;
    logic                      full;
    logic                      empty;
    logic                      err;

    modport master (
        output alloc_val, commit_val, commit_seq_num,
               squash_val, squash_seq_num, squash_target,
        input  alloc_rdy, alloc_seq_num, redirect_val, redirect_target,
               inflight, full, empty, err
    );

    modport slave (
        input  alloc_val, commit_val, commit_seq_num,
               squash_val, squash_seq_num, squash_target,
        output alloc_rdy, alloc_seq_num, redirect_val, redirect_target,
               inflight, full, empty, err
    );
endinterface

// File: rtl/seq_num_alloc.sv
// In-order sequence-number allocator: hands out numbers at tail, retires at head,
// rewinds tail on an accepted squash and pulses a registered fetch redirect.
module seq_num_alloc #(
    parameter int p_seq_num_bits = 5
) (
    input  logic          clk,
    input  logic          rst,
    seq_num_alloc_if.slave bus
);
    localparam int W = p_seq_num_bits;
    localparam logic [W:0]   CAP   = {1'b1, {W{1'b0}}};
    localparam logic [W-1:0] ONE_S = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W:0]   ONE_C = {{W{1'b0}}, 1'b1};

    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic [W:0]   count_q, count_d;
    logic         redirect_val_q, redirect_val_d;
    logic [31:0]  redirect_target_q, redirect_target_d;
    logic         err_q, err_d;

    logic         commit_ok;
    logic         commit_of_s;
    logic         squash_acc;
    logic         alloc_fire;
    logic [W-1:0] head_pc;
    logic [W:0]   count_pc;
    logic [W-1:0] s_off;

    assign bus.alloc_seq_num   = tail_q;
    assign bus.alloc_rdy       = rst && (count_q != CAP) && !bus.squash_val;
    assign bus.inflight        = count_q;
    assign bus.full            = rst && (count_q == CAP);
    assign bus.empty           = !rst || (count_q == '0);
    assign bus.err             = err_q;
    assign bus.redirect_val    = redirect_val_q;
    assign bus.redirect_target = redirect_target_q;

    always_comb begin
        commit_ok   = bus.commit_val && (count_q != '0) && (bus.commit_seq_num == head_q);
        head_pc     = commit_ok ? head_q + ONE_S : head_q;
        count_pc    = commit_ok ? count_q - ONE_C : count_q;
        // Distance of the squasher from the post-commit head; in flight iff below count.
        s_off       = bus.squash_seq_num - head_pc;
        commit_of_s = commit_ok && (bus.commit_seq_num == bus.squash_seq_num);
        squash_acc  = bus.squash_val && (commit_of_s || ({1'b0, s_off} < count_pc));
        alloc_fire  = bus.alloc_val && bus.alloc_rdy;

        head_d            = head_pc;
        tail_d            = tail_q;
        count_d           = count_pc;
        redirect_val_d    = 1'b0;
        redirect_target_d = redirect_target_q;
        err_d             = err_q;

        if (bus.commit_val && !commit_ok) begin
            err_d = 1'b1;
        end

        if (squash_acc) begin
            tail_d            = bus.squash_seq_num + ONE_S;
            // s_off+1 spans 1..C, so a full queue squashed at its youngest keeps count C.
            count_d           = commit_of_s ? '0 : {1'b0, s_off} + ONE_C;
            redirect_val_d    = 1'b1;
            redirect_target_d = bus.squash_target;
        end else if (alloc_fire) begin
            tail_d  = tail_q + ONE_S;
            count_d = count_pc + ONE_C;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q            <= '0;
            tail_q            <= '0;
            count_q           <= '0;
            redirect_val_q    <= 1'b0;
            redirect_target_q <= '0;
            err_q             <= 1'b0;
        end else begin
            head_q            <= head_d;
            tail_q            <= tail_d;
            count_q           <= count_d;
            redirect_val_q    <= redirect_val_d;
            redirect_target_q <= redirect_target_d;
            err_q             <= err_d;
        end
    end
endmodule

// File: tb/tb_seq_num_alloc.sv
// Bench for seq_num_alloc: queue-based reference model checked every negedge,
// directed scenarios with literal expectations, then randomized traffic.
module tb_seq_num_alloc;
    localparam int W = 3;
    localparam int C = 1 << W;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    seq_num_alloc_if #(.p_seq_num_bits(W)) bus ();
    seq_num_alloc #(.p_seq_num_bits(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;
    bit verbose = 1'b1;

    // Reference model: the in-flight set is literally a queue of sequence numbers.
    int          m_fifo[$];
    int          n_fifo[$];
    int          m_tail = 0, n_tail = 0;
    bit          m_err = 0, n_err = 0;
    bit          m_rv = 0, n_rv = 0;
    logic [31:0] m_rt = '0, n_rt = '0;

    function automatic void chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("alloc_rdy", bus.alloc_rdy, longint'(rst && m_fifo.size() < C && !bus.squash_val));
            chk("alloc_seq_num", bus.alloc_seq_num, m_tail);
            chk("inflight", bus.inflight, m_fifo.size());
            chk("full", bus.full, longint'(rst && m_fifo.size() == C));
            chk("empty", bus.empty, longint'(!rst || m_fifo.size() == 0));
            chk("err", bus.err, m_err);
            chk("redirect_val", bus.redirect_val, m_rv);
            chk("redirect_target", bus.redirect_target, m_rt);
        end
    end

    task automatic model_step();
        int committed;
        int idx;
        int s;
        n_fifo = m_fifo;
        n_tail = m_tail;
        n_err  = m_err;
        n_rv   = 1'b0;
        n_rt   = m_rt;
        if (!rst) begin
            n_fifo.delete();
            n_tail = 0;
            n_err  = 1'b0;
            n_rt   = '0;
        end else begin
            committed = -1;
            if (bus.commit_val) begin
                if (n_fifo.size() > 0 && n_fifo[0] == int'(bus.commit_seq_num)) begin
                    committed = n_fifo[0];
                    void'(n_fifo.pop_front());
                end else begin
                    n_err = 1'b1;
                end
            end
            if (bus.squash_val) begin
                s   = int'(bus.squash_seq_num);
                idx = -1;
                foreach (n_fifo[k]) if (n_fifo[k] == s) idx = k;
                if (committed == s) begin
                    n_fifo.delete();
                end
                if (committed == s || idx >= 0) begin
                    while (n_fifo.size() > idx + 1) void'(n_fifo.pop_back());
                    n_tail = (s + 1) % C;
                    n_rv   = 1'b1;
                    n_rt   = bus.squash_target;
                end
            end else if (bus.alloc_val && m_fifo.size() < C) begin
                n_fifo.push_back(m_tail);
                n_tail = (m_tail + 1) % C;
            end
        end
    endtask

    task automatic idle();
        bus.alloc_val      = 1'b0;
        bus.commit_val     = 1'b0;
        bus.commit_seq_num = '0;
        bus.squash_val     = 1'b0;
        bus.squash_seq_num = '0;
        bus.squash_target  = '0;
    endtask

    // One clock: model computes next state from the held inputs, then inputs return to idle.
    task automatic tick();
        @(negedge clk);
        model_step();
        if (verbose)
            $display("txn t=%0t rst=%0b alloc=%0b commit=%0b/%0d squash=%0b/%0d inflight_next=%0d",
                     $time, rst, bus.alloc_val, bus.commit_val, bus.commit_seq_num,
                     bus.squash_val, bus.squash_seq_num, n_fifo.size());
        @(posedge clk);
        #1;
        m_fifo = n_fifo;
        m_tail = n_tail;
        m_err  = n_err;
        m_rv   = n_rv;
        m_rt   = n_rt;
        cmp_en = 1'b1;
        idle();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic do_alloc(int n);
        for (int i = 0; i < n; i++) begin
            bus.alloc_val = 1'b1;
            tick();
        end
    endtask

    initial begin
        idle();
        rst = 1'b0;
        tick();
        tick();
        chk("rst_empty", bus.empty, 1);
        chk("rst_alloc_rdy", bus.alloc_rdy, 0);
        chk("rst_full", bus.full, 0);
        chk("rst_inflight", bus.inflight, 0);
        rst = 1'b1;

        // Fill then in-order commits, then an out-of-order commit.
        for (int i = 0; i < 8; i++) begin
            chk("fill_seq", bus.alloc_seq_num, i);
            bus.alloc_val = 1'b1;
            tick();
        end
        chk("fill_full", bus.full, 1);
        chk("fill_rdy", bus.alloc_rdy, 0);
        chk("fill_inflight", bus.inflight, 8);
        for (int i = 0; i < 3; i++) begin
            bus.commit_val = 1'b1;
            bus.commit_seq_num = 3'(i);
            tick();
        end
        chk("commit_inflight", bus.inflight, 5);
        chk("commit_full", bus.full, 0);
        chk("commit_err_clear", bus.err, 0);
        bus.commit_val = 1'b1;
        bus.commit_seq_num = 3'd5;
        tick();
        chk("bad_commit_err", bus.err, 1);
        chk("bad_commit_inflight", bus.inflight, 5);

        // Squash mid-queue.
        do_reset();
        do_alloc(6);
        bus.squash_val = 1'b1;
        bus.squash_seq_num = 3'd2;
        bus.squash_target = 32'h8000_1000;
        tick();
        chk("sq_redirect_val", bus.redirect_val, 1);
        chk("sq_redirect_target", bus.redirect_target, 32'h8000_1000);
        chk("sq_inflight", bus.inflight, 3);
        chk("sq_next_seq", bus.alloc_seq_num, 3);
        tick();
        chk("sq_pulse_end", bus.redirect_val, 0);

        // Commit and squash of the same number in one cycle; then an unallocated squash.
        do_reset();
        do_alloc(4);
        bus.commit_val = 1'b1;
        bus.commit_seq_num = 3'd0;
        bus.squash_val = 1'b1;
        bus.squash_seq_num = 3'd0;
        bus.squash_target = 32'h0000_1234;
        tick();
        chk("cs_inflight", bus.inflight, 0);
        chk("cs_tail", bus.alloc_seq_num, 1);
        chk("cs_redirect", bus.redirect_val, 1);
        tick();
        chk("cs_pulse_end", bus.redirect_val, 0);
        do_reset();
        do_alloc(4);
        bus.squash_val = 1'b1;
        bus.squash_seq_num = 3'd6;
        tick();
        chk("unalloc_redirect", bus.redirect_val, 0);
        chk("unalloc_err", bus.err, 0);
        chk("unalloc_inflight", bus.inflight, 4);

        // Wrap-around, stale squash, allocation blocked by squash.
        do_reset();
        do_alloc(8);
        for (int i = 0; i < 8; i++) begin
            bus.commit_val = 1'b1;
            bus.commit_seq_num = 3'(i);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            chk("wrap_seq", bus.alloc_seq_num, i);
            bus.alloc_val = 1'b1;
            tick();
        end
        bus.squash_val = 1'b1;
        bus.squash_seq_num = 3'd7;
        bus.alloc_val = 1'b1;
        #1;
        chk("sq_blocks_rdy", bus.alloc_rdy, 0);
        tick();
        chk("stale_redirect", bus.redirect_val, 0);
        chk("stale_inflight", bus.inflight, 3);
        chk("stale_seq", bus.alloc_seq_num, 3);

        // Reset discards a pending redirect.
        do_reset();
        do_alloc(6);
        bus.squash_val = 1'b1;
        bus.squash_seq_num = 3'd3;
        bus.squash_target = 32'hdead_beef;
        tick();
        chk("pre_rst_inflight", bus.inflight, 4);
        chk("pre_rst_redirect", bus.redirect_val, 1);
        rst = 1'b0;
        tick();
        chk("mid_rst_redirect", bus.redirect_val, 0);
        chk("mid_rst_inflight", bus.inflight, 0);
        rst = 1'b1;
        tick();
        chk("post_rst_seq", bus.alloc_seq_num, 0);
        chk("post_rst_redirect", bus.redirect_val, 0);

        // Randomized traffic against the model.
        verbose = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            rst = ($urandom_range(0, 199) != 0);
            bus.alloc_val = ($urandom_range(0, 99) < 60);
            if ($urandom_range(0, 99) < 45) begin
                bus.commit_val = 1'b1;
                if (m_fifo.size() > 0 && $urandom_range(0, 99) < 85)
                    bus.commit_seq_num = 3'(m_fifo[0]);
                else
                    bus.commit_seq_num = 3'($urandom_range(0, C - 1));
            end
            if ($urandom_range(0, 99) < 15) begin
                bus.squash_val = 1'b1;
                bus.squash_target = $urandom();
                if (m_fifo.size() > 0 && $urandom_range(0, 1) == 1)
                    bus.squash_seq_num = 3'(m_fifo[$urandom_range(0, m_fifo.size() - 1)]);
                else
                    bus.squash_seq_num = 3'($urandom_range(0, C - 1));
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_num_alloc.md
# seq_num_alloc

Sequence-number allocator and in-flight tracker that sits at the receiving end of the squash and commit notifications.
- Hands out sequence numbers in program order to decode.
- Retires them in order on commit notifications.
- On a granted squash: rewinds the allocation pointer to just past the squashing instruction and emits a one-cycle registered fetch redirect to the squash target.
- Owns the sequence-number space that every squash arbiter and age comparator in the pipeline reasons about.

## Interface
- p_seq_num_bits, 5, sequence-number width; capacity C = 2^p_seq_num_bits in-flight instructions
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset (rst == 0 resets on the rising edge of clk)
- alloc_val  in  1  decode requests a sequence number
- alloc_rdy  out  1  allocation possible this cycle
- alloc_seq_num  out  p_seq_num_bits  number granted when alloc_val && alloc_rdy
- commit_val  in  1  commit notification valid
- commit_seq_num  in  p_seq_num_bits  sequence number being committed
- squash_val  in  1  granted squash valid
- squash_seq_num  in  p_seq_num_bits  squashing instruction; all younger are squashed, it survives
- squash_target  in  32  redirect PC
- redirect_val  out  1  fetch redirect pulse
- redirect_target  out  32  fetch redirect PC
- inflight  out  p_seq_num_bits+1  number of allocated, uncommitted entries
- full  out  1  inflight == C
- empty  out  1  inflight == 0
- err  out  1  sticky protocol-violation flag

## Operation
- State registers:
  - head: oldest in-flight sequence number.
  - tail: next sequence number to allocate.
  - count: p_seq_num_bits+1 bits.
  - redirect_val and redirect_target.
  - err.
- All sequence arithmetic is modulo C. A number s is in flight iff (s - head) mod C < count.
- alloc_seq_num = tail.
- alloc_rdy = rst && !full && !squash_val. Squash blocks allocation combinationally.
- Allocate (alloc_val && alloc_rdy): tail <= tail+1, count += 1.
- Commit (commit_val):
  - If count != 0 and commit_seq_num == head: head <= head+1, count -= 1.
  - Otherwise the commit is ignored and err <= 1.
- Squash (squash_val) with s = squash_seq_num:
  - Accepted iff s is in flight against the post-commit state. A same-cycle legal commit of s itself counts as in flight.
  - Accepted, no same-cycle commit of s: tail <= s+1, count <= (s+1 - head') mod C with head' the post-commit head, count computed in p_seq_num_bits+1 bits. If s+1-head' wraps to 0 with the queue previously full, count = C.
  - Accepted with a same-cycle commit of s: tail <= s+1, count <= 0.
  - Accepted: redirect_val <= 1, redirect_target <= squash_target.
  - Not accepted (stale or unallocated s): no state change, no redirect, err is not set. Stale squashes are legal.
- Same-cycle priority: commit is applied first, then squash. Allocation cannot coincide with squash.
- err clears only on reset.

## Timing
- Reset (rst == 0 at a clock edge): head=0, tail=0, count=0, redirect_val=0, redirect_target=0, err=0. While rst == 0, alloc_rdy=0, full=0, empty=1.
- alloc_seq_num, alloc_rdy, inflight, full and empty are combinational from registers, plus squash_val for alloc_rdy only.
- Allocation, commit and squash take effect at the next rising edge. A number allocated at edge N is committable in the cycle after edge N.
- redirect_val is high for exactly one cycle, the cycle after the accepted squash. Back-to-back accepted squashes produce back-to-back pulses, each carrying its own target.
- Reset mid-operation discards all in-flight state and any pending redirect at that edge.
- Full boundary: at count == C, alloc_rdy=0. A same-cycle commit does not re-enable allocation until the next cycle.
- Wrap-around: tail and head roll from C-1 to 0 with no special casing.

## Test plan
- Reset then 8 allocations, p_seq_num_bits=3 → seq nums 0..7 in order; full=1 and alloc_rdy=0 after the 8th; inflight=8.
- In-order commits 0,1,2 after the fill → head=3, inflight=5, full=0; commit 5 while head=3 → ignored, err=1.
- Allocations 0..5, squash s=2 target 0x8000_1000 → next cycle redirect_val=1 and target 0x8000_1000 for one cycle, inflight=3, next alloc_seq_num=3.
- Same cycle commit 0 and squash 0 with inflight=4 → inflight=0, tail=1, one redirect pulse; squash s=6 with only 0..3 allocated → no redirect, no err.
- Wrap: 8 allocations, 8 commits, 3 allocations → seq nums 0,1,2 reissued; squash s=7 (stale) ignored; alloc_val held during squash_val → no allocation that cycle.
- Reset asserted one cycle after an accepted squash and with 4 in flight → redirect_val=0, inflight=0, alloc_seq_num=0 the cycle after reset deasserts.
